sweep_peak_detect: RTL and testbench

SWEEP_PEAK_DETECT -- requirements
Module: sweep_peak_detect

---
 rtl/sweep_peak_pkg.sv | 17 +
 rtl/sweep_peak_detect_tracker.sv | 53 +++++
 rtl/sweep_peak_detect.sv | 175 +++++++++++++++++
 tb/tb_sweep_peak_detect.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_peak_pkg.sv
// Shared types and default widths for the sweep peak detector.
// Imported by the tracker and the top level.
package sweep_peak_pkg;

  localparam int SWEEP_W = 18;
  localparam int DATA_W  = 16;
  localparam int HOLD_W  = 16;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    UP,
    DOWN
  } state_t;

endpackage

// File: rtl/sweep_peak_detect_tracker.sv
// Running extremum (max or min) of eligible samples in a segment.
// restart_i drops the old segment; the same-cycle sample may seed it.
module sweep_extremum_tracker
  import sweep_peak_pkg::*;
#(
  parameter bit IS_MAX = 1'b1,
  parameter int DW     = DATA_W,
  parameter int PW     = SWEEP_W
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 restart_i,
  input  logic                 en_i,
  input  logic signed [DW-1:0] val_i,
  input  logic signed [PW-1:0] pos_i,
  output logic signed [DW-1:0] val_o,
  output logic signed [PW-1:0] pos_o,
  output logic                 seen_o
);

  logic                 seen_q, seen_d;
  logic signed [DW-1:0] val_q, val_d;
  logic signed [PW-1:0] pos_q, pos_d;
  logic                 base, better, take;

  // Strictly better sample or first eligible one replaces the record.
  always_comb begin
    base   = restart_i ? 1'b0 : seen_q;
    better = IS_MAX ? (val_i > val_q) : (val_i < val_q);
    take   = en_i && (!base || better);
    seen_d = take || base;
    val_d  = take ? val_i : val_q;
    pos_d  = take ? pos_i : pos_q;
  end

  // Record registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      seen_q <= 1'b0;
      val_q  <= '0;
      pos_q  <= '0;
    end else begin
      seen_q <= seen_d;
      val_q  <= val_d;
      pos_q  <= pos_d;
    end
  end

  assign val_o  = val_q;
  assign pos_o  = pos_q;
  assign seen_o = seen_q;

endmodule

// File: rtl/sweep_peak_detect.sv
// Per-segment peak detector for a triangle sweep.
// Define SWEEP_PEAK_MIN_EN to add the minimum tracker.
module sweep_peak_detect
  import sweep_peak_pkg::*;
#(
  parameter int SWEEP_SIZE = SWEEP_W,
  parameter int DATA_SIZE  = DATA_W
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         on_in,
  input  logic signed [SWEEP_SIZE-1:0] sweep_in,
  input  logic signed [DATA_SIZE-1:0]  data_in,
  input  logic        [HOLD_W-1:0]     holdoff_in,
  output logic signed [DATA_SIZE-1:0]  peak_val_out,
  output logic signed [SWEEP_SIZE-1:0] peak_pos_out,
  output logic signed [DATA_SIZE-1:0]  min_val_out,
  output logic signed [SWEEP_SIZE-1:0] min_pos_out,
  output logic                         dir_out,
  output logic                         empty_out,
  output logic                         valid_out,
  output logic        [CNT_W-1:0]      seg_count_out
);

  state_t                      state_q;
  logic signed [SWEEP_SIZE-1:0] sweep_s1_q, sweep_prev_q;
  logic signed [DATA_SIZE-1:0]  data_s1_q;
  logic        [HOLD_W-1:0]     hold_q, hold_d;
  logic signed [DATA_SIZE-1:0]  peak_val_q;
  logic signed [SWEEP_SIZE-1:0] peak_pos_q;
  logic                         dir_q, empty_q, valid_q;
  logic        [CNT_W-1:0]      cnt_q;

  logic rise, fall, active, turn, elig;
  logic restart, en;
  logic signed [DATA_SIZE-1:0]  max_val;
  logic signed [SWEEP_SIZE-1:0] max_pos;
  logic                         max_seen;

  // Direction, turnaround and sample eligibility from the S1 stage.
  always_comb begin
    rise    = sweep_s1_q > sweep_prev_q;
    fall    = sweep_s1_q < sweep_prev_q;
    active  = on_in && (state_q != IDLE);
    turn    = on_in && (((state_q == UP) && fall) ||
                        ((state_q == DOWN) && rise));
    elig    = turn ? (holdoff_in == '0) : (hold_q == '0);
    restart = !active || turn;
    en      = active && elig;
    hold_d  = '0;
    if (active && (state_q != ARM)) begin
      if (turn)
        hold_d = (holdoff_in == '0) ? '0 : holdoff_in - 1'b1;
      else if (hold_q != '0)
        hold_d = hold_q - 1'b1;
    end
  end

  // S1 sample stage and holdoff counter.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sweep_s1_q   <= '0;
      sweep_prev_q <= '0;
      data_s1_q    <= '0;
      hold_q       <= '0;
    end else begin
      sweep_s1_q   <= sweep_in;
      sweep_prev_q <= sweep_s1_q;
      data_s1_q    <= data_in;
      hold_q       <= hold_d;
    end
  end

  sweep_extremum_tracker #(
    .IS_MAX(1'b1),
    .DW    (DATA_SIZE),
    .PW    (SWEEP_SIZE)
  ) u_max (
    .clk_i    (clk_in),
    .rst_n_i  (rst_n_in),
    .restart_i(restart),
    .en_i     (en),
    .val_i    (data_s1_q),
    .pos_i    (sweep_s1_q),
    .val_o    (max_val),
    .pos_o    (max_pos),
    .seen_o   (max_seen)
  );

  // Segment FSM with registered results, published on turnaround.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      peak_val_q <= '0;
      peak_pos_q <= '0;
      dir_q      <= 1'b0;
      empty_q    <= 1'b0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      valid_q <= 1'b0;
      if (!on_in) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: state_q <= ARM;
          ARM: begin
            if (rise)      state_q <= UP;
            else if (fall) state_q <= DOWN;
          end
          UP:      if (fall) state_q <= DOWN;
          DOWN:    if (rise) state_q <= UP;
          default: state_q <= IDLE;
        endcase
      end
      if (turn) begin
        valid_q <= 1'b1;
        dir_q   <= (state_q == DOWN);
        empty_q <= !max_seen;
        cnt_q   <= cnt_q + 1'b1;
        if (max_seen) begin
          peak_val_q <= max_val;
          peak_pos_q <= max_pos;
        end
      end
    end
  end

`ifdef SWEEP_PEAK_MIN_EN
  logic signed [DATA_SIZE-1:0]  min_val, min_val_q;
  logic signed [SWEEP_SIZE-1:0] min_pos, min_pos_q;
  logic                         min_seen;

  sweep_extremum_tracker #(
    .IS_MAX(1'b0),
    .DW    (DATA_SIZE),
    .PW    (SWEEP_SIZE)
  ) u_min (
    .clk_i    (clk_in),
    .rst_n_i  (rst_n_in),
    .restart_i(restart),
    .en_i     (en),
    .val_i    (data_s1_q),
    .pos_i    (sweep_s1_q),
    .val_o    (min_val),
    .pos_o    (min_pos),
    .seen_o   (min_seen)
  );

  // Minimum result registers, same publish rule as the peak.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      min_val_q <= '0;
      min_pos_q <= '0;
    end else if (turn && min_seen) begin
      min_val_q <= min_val;
      min_pos_q <= min_pos;
    end
  end

  assign min_val_out = min_val_q;
  assign min_pos_out = min_pos_q;
`else
  assign min_val_out = '0;
  assign min_pos_out = '0;
`endif

  assign peak_val_out  = peak_val_q;
  assign peak_pos_out  = peak_pos_q;
  assign dir_out       = dir_q;
  assign empty_out     = empty_q;
  assign valid_out     = valid_q;
  assign seg_count_out = cnt_q;

endmodule

// File: tb/tb_sweep_peak_detect.sv
// Scoreboard bench for sweep_peak_detect.
// Directed triangle sweeps with hand-computed segment results.
module tb_sweep_peak_detect;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               on = 1'b0;
  logic signed [17:0] sweep = '0;
  logic signed [15:0] data = '0;
  logic        [15:0] holdoff = '0;
  logic signed [15:0] pv, mv;
  logic signed [17:0] pp, mp;
  logic               dir, empty, valid;
  logic        [15:0] cnt;

  typedef struct {
    logic               dir;
    logic               empty;
    logic signed [15:0] pv;
    logic signed [17:0] pp;
    logic signed [15:0] mv;
    logic signed [17:0] mp;
    logic        [15:0] cnt;
  } res_t;

  res_t sb[$];
  res_t cur;
  res_t e;
  int   checks = 0;
  int   fails = 0;
  int   exp_cnt = 0;

  sweep_peak_detect dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .on_in        (on),
    .sweep_in     (sweep),
    .data_in      (data),
    .holdoff_in   (holdoff),
    .peak_val_out (pv),
    .peak_pos_out (pp),
    .min_val_out  (mv),
    .min_pos_out  (mp),
    .dir_out      (dir),
    .empty_out    (empty),
    .valid_out    (valid),
    .seg_count_out(cnt)
  );

  always #5 clk = ~clk;

  function automatic bit same(res_t r);
    return dir === r.dir && empty === r.empty &&
           pv === r.pv && pp === r.pp &&
           mv === r.mv && mp === r.mp &&
           cnt === r.cnt;
  endfunction

  task automatic show(string nm, res_t r);
    $display("FAIL %s: got dir=%0d empty=%0d pv=%0d pp=%0d mv=%0d mp=%0d cnt=%0d want dir=%0d empty=%0d pv=%0d pp=%0d mv=%0d mp=%0d cnt=%0d",
             nm, dir, empty, pv, pp, mv, mp, cnt,
             r.dir, r.empty, r.pv, r.pp, r.mv, r.mp, r.cnt);
  endtask

  // Monitor: pop and compare on every valid pulse.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got valid=1 cnt=%0d want no result", cnt);
      end else begin
        e = sb.pop_front();
        if (!same(e)) begin
          fails++;
          show($sformatf("result_%0d", e.cnt), e);
        end
        cur = e;
      end
    end
  end

  task automatic push(input bit d, input bit em,
                      input int v, input int p,
                      input int minv, input int minp);
    res_t r;
    exp_cnt++;
    r.dir   = d;
    r.empty = em;
    r.pv    = 16'(v);
    r.pp    = 18'(p);
`ifdef SWEEP_PEAK_MIN_EN
    r.mv    = 16'(minv);
    r.mp    = 18'(minp);
`else
    r.mv    = 16'(minv * 0);
    r.mp    = 18'(minp * 0);
`endif
    r.cnt   = 16'(exp_cnt);
    sb.push_back(r);
  endtask

  // mode 0: -|s-40|, 1: s, 2: constant 7.
  task automatic step(input int s, input int m);
    int d;
    d = s - 40;
    if (d < 0) d = -d;
    sweep = 18'(s);
    case (m)
      0:       data = 16'(-d);
      1:       data = 16'(s);
      default: data = 16'sd7;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic ramp(input int a, input int b, input int m);
    if (a <= b) for (int s = a; s <= b; s++) step(s, m);
    else        for (int s = a; s >= b; s--) step(s, m);
  endtask

  task automatic start(input int v, input int m);
    on = 1'b0;
    repeat (3) step(v, m);
    on = 1'b1;
  endtask

  task automatic stop_check(input string nm);
    on = 1'b0;
    repeat (4) step(0, 1);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got pending=%0d want 0", nm, sb.size());
      sb.delete();
    end
    checks++;
    if (!same(cur)) begin
      fails++;
      show($sformatf("%s_hold", nm), cur);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    cur = '{default: '0};
    on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (!same(cur) || valid !== 1'b0) begin
      fails++;
      show("reset_state", cur);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    on = 1'b0;

    // Full ramps, holdoff 0, peak at sweep 40.
    push(0, 0, 0, 40, -140, -100);
    push(1, 0, 0, 40, -140, -100);
    push(0, 0, 0, 40, -139, -99);
    start(-100, 0);
    ramp(-100, 100, 0);
    ramp(99, -100, 0);
    ramp(-99, 100, 0);
    ramp(99, 97, 0);
    stop_check("ramp");

    // Flat run of 5 inside the up ramp.
    push(0, 0, 20, 20, 0, 0);
    push(1, 0, 19, 19, 0, 0);
    start(0, 1);
    ramp(0, 4, 1);
    repeat (10) step(5, 1);
    ramp(6, 20, 1);
    ramp(19, 0, 1);
    ramp(1, 3, 1);
    stop_check("flat");

    // Holdoff longer than each segment.
    holdoff = 16'd300;
    push(0, 0, 199, 199, 0, 0);
    push(1, 1, 199, 199, 0, 0);
    push(0, 1, 199, 199, 0, 0);
    start(0, 1);
    ramp(0, 199, 1);
    ramp(198, -1, 1);
    ramp(0, 199, 1);
    ramp(198, 196, 1);
    stop_check("holdoff");

    // Constant data, holdoff 3 after turnaround.
    holdoff = 16'd3;
    push(0, 0, 7, 10, 7, 10);
    push(1, 0, 7, 26, 7, 26);
    start(10, 2);
    ramp(10, 30, 2);
    ramp(29, 10, 2);
    ramp(11, 13, 2);
    stop_check("const");

    // on drops mid-segment: nothing published.
    holdoff = 16'd0;
    start(0, 1);
    ramp(0, 20, 1);
    stop_check("on_drop");

    // Reset lands on the turnaround edge.
    start(0, 1);
    ramp(0, 10, 1);
    step(9, 1);
    rst_n = 1'b0;
    step(8, 1);
    rst_n = 1'b1;
    on = 1'b0;
    cur = '{default: '0};
    exp_cnt = 0;
    @(negedge clk);
    checks++;
    if (!same(cur) || valid !== 1'b0) begin
      fails++;
      show("reset_mid_turn", cur);
    end
    @(posedge clk);
    #1;
    push(0, 0, 5, 5, 0, 0);
    push(1, 0, 4, 4, 2, 2);
    start(0, 1);
    ramp(0, 5, 1);
    ramp(4, 2, 1);
    ramp(3, 5, 1);
    stop_check("post_reset");

    // data = sweep over the full range.
    push(0, 0, 100, 100, -100, -100);
    push(1, 0, 99, 99, -100, -100);
    start(-100, 1);
    ramp(-100, 100, 1);
    ramp(99, -100, 1);
    ramp(-99, -97, 1);
    stop_check("linear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
